// File: rtl/input_buffer_scheduler_pkg.sv
// Shared types and geometry helpers for the input buffer scheduling path.
package input_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    WAIT_RES,
    DONE
  } sched_state_e;

  // Rows of input pixels covered by one PE-row block.
  function automatic int lm(input int poy, input int stride);
    return (stride + 1) * poy - stride;
  endfunction

  // Guarded so a bad geometry reaches the elaboration check instead of a divide by zero.
  function automatic int nrow(input int ih, input int poy, input int stride);
    int l;
    l = lm(poy, stride);
    return (l < 1) ? 0 : ih / l;
  endfunction

  function automatic int ncol(input int iw, input int burst);
    return (burst < 1) ? 0 : iw / burst;
  endfunction

  function automatic int img_sz(input int ih, input int iw);
    return ih * iw;
  endfunction

  // Index register width able to hold 0..n.
  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DEF_LM     = lm(3, 2);
  localparam int DEF_NROW   = nrow(224, 3, 2);
  localparam int DEF_NCOL   = ncol(224, 32);
  localparam int DEF_IMG_SZ = img_sz(224, 224);

endpackage

// File: rtl/input_buffer_scheduler_if.sv
// Control bus between layer controller / input_buffer / compute array and the scheduler.
interface input_buffer_scheduler_if
  import input_buffer_pkg::*;
#(
  parameter int AW     = 32,
  parameter int IW     = 224,
  parameter int IH     = 224,
  parameter int IN     = 10,
  parameter int POY    = 3,
  parameter int STRIDE = 2,
  parameter int BURST  = 32
);
  localparam int IMG_W = idx_w(IN);
  localparam int ROW_W = idx_w(nrow(IH, POY, STRIDE));
  localparam int COL_W = idx_w(ncol(IW, BURST));

  logic             start;
  logic [AW-1:0]    base_addr;
  logic             blkend;
  logic             result_valid;
  logic             data_load;
  logic             init_addr_en;
  logic [AW-1:0]    init_addr;
  logic             busy;
  logic             done;
  logic [IMG_W-1:0] img_idx;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  // Scheduler side.
  modport master (
    input  start, base_addr, blkend, result_valid,
    output data_load, init_addr_en, init_addr, busy, done, img_idx, row_idx, col_idx
  );

  // Environment side (controller, buffer, compute array).
  modport slave (
    output start, base_addr, blkend, result_valid,
    input  data_load, init_addr_en, init_addr, busy, done, img_idx, row_idx, col_idx
  );

endinterface

// File: rtl/input_buffer_scheduler_blk_index_counter.sv
// Cascaded column/row/image block counter with wrap flags.
module blk_index_counter #(
  parameter int IN    = 10,
  parameter int NROW  = 32,
  parameter int NCOL  = 7,
  parameter int IMG_W = 4,
  parameter int ROW_W = 6,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [IMG_W-1:0] img_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             col_wrap_o,
  output logic             row_wrap_o,
  output logic             last_blk_o
);

  logic [IMG_W-1:0] img_q, img_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             img_last;

  assign col_wrap_o = (col_q == COL_W'(NCOL - 1));
  assign row_wrap_o = (row_q == ROW_W'(NROW - 1));
  assign img_last   = (img_q == IMG_W'(IN - 1));
  assign last_blk_o = col_wrap_o & row_wrap_o & img_last;

  assign img_o = img_q;
  assign row_o = row_q;
  assign col_o = col_q;

  // Next index: column fastest, row carries on column wrap, image on row wrap.
  // On the final block col/row wrap to 0 while the image index holds.
  always_comb begin
    img_d = img_q;
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      img_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      col_d = col_wrap_o ? '0 : col_q + COL_W'(1);
      if (col_wrap_o) begin
        row_d = row_wrap_o ? '0 : row_q + ROW_W'(1);
        if (row_wrap_o && !img_last) img_d = img_q + IMG_W'(1);
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      img_q <= img_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/input_buffer_scheduler.sv
// Walks image/row-block/column-block loads of a batch through input_buffer.
module input_buffer_scheduler
  import input_buffer_pkg::*;
#(
  parameter int AW     = 32,
  parameter int IW     = 224,
  parameter int IH     = 224,
  parameter int IN     = 10,
  parameter int POY    = 3,
  parameter int STRIDE = 2,
  parameter int BURST  = 32
) (
  input logic                     clk,
  input logic                     rst,
  input_buffer_scheduler_if.master bus
);

  localparam int LM     = lm(POY, STRIDE);
  localparam int NROW   = nrow(IH, POY, STRIDE);
  localparam int NCOL   = ncol(IW, BURST);
  localparam int IMG_SZ = img_sz(IH, IW);
  localparam int IMG_W  = idx_w(IN);
  localparam int ROW_W  = idx_w(NROW);
  localparam int COL_W  = idx_w(NCOL);
  localparam logic [AW-1:0] IMG_STEP = AW'(IMG_SZ);

  if (LM < 1 || NCOL < 1 || NROW < 1) begin : g_bad_cfg
    $error("input_buffer_scheduler: bad geometry LM=%0d NROW=%0d NCOL=%0d", LM, NROW, NCOL);
  end

  sched_state_e  state_q, state_d;
  logic [AW-1:0] img_addr_q, img_addr_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic          data_load_q, data_load_d;
  logic          init_addr_en_q, init_addr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cnt_clr, cnt_adv;
  logic          col_wrap, row_wrap, last_blk;

  blk_index_counter #(
    .IN    (IN),
    .NROW  (NROW),
    .NCOL  (NCOL),
    .IMG_W (IMG_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .img_o      (bus.img_idx),
    .row_o      (bus.row_idx),
    .col_o      (bus.col_idx),
    .col_wrap_o (col_wrap),
    .row_wrap_o (row_wrap),
    .last_blk_o (last_blk)
  );

  // Next state plus registered-output values; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    img_addr_d = img_addr_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = INIT;
          img_addr_d = bus.base_addr;
          cnt_clr    = 1'b1;
        end
      end
      INIT: state_d = LOAD;
      LOAD: begin
        if (bus.blkend) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.result_valid) begin
          cnt_adv = 1'b1;
          if (!(col_wrap && row_wrap)) begin
            state_d = LOAD;
          end else if (!last_blk) begin
            state_d    = INIT;
            img_addr_d = img_addr_q + IMG_STEP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    data_load_d    = (state_d == INIT) || (state_d == LOAD);
    init_addr_en_d = (state_d == INIT);
    init_addr_d    = (state_d == INIT) ? img_addr_d : init_addr_q;
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      img_addr_q     <= '0;
      init_addr_q    <= '0;
      data_load_q    <= 1'b0;
      init_addr_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      img_addr_q     <= img_addr_d;
      init_addr_q    <= init_addr_d;
      data_load_q    <= data_load_d;
      init_addr_en_q <= init_addr_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.data_load    = data_load_q;
  assign bus.init_addr_en = init_addr_en_q;
  assign bus.init_addr    = init_addr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_input_buffer_scheduler.sv
// Directed bench: 2x2x2 block batch (DUT a) and 1x1x1 degenerate batch (DUT b).
module tb_input_buffer_scheduler;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  input_buffer_scheduler_if #(.AW(32), .IW(64), .IH(14), .IN(2), .POY(3), .STRIDE(2), .BURST(32)) a ();
  input_buffer_scheduler_if #(.AW(32), .IW(32), .IH(7),  .IN(1), .POY(3), .STRIDE(2), .BURST(32)) b ();

  input_buffer_scheduler #(.AW(32), .IW(64), .IH(14), .IN(2), .POY(3), .STRIDE(2), .BURST(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  input_buffer_scheduler #(.AW(32), .IW(32), .IH(7), .IN(1), .POY(3), .STRIDE(2), .BURST(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters (cumulative; tests take deltas).
  int   rise_a, ia_a, done_a, rise_b, done_b;
  logic dl_prev_a, dl_prev_b;
  initial begin
    rise_a = 0; ia_a = 0; done_a = 0; rise_b = 0; done_b = 0;
    dl_prev_a = 1'b0; dl_prev_b = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (a.data_load === 1'b1 && dl_prev_a !== 1'b1) rise_a++;
      if (a.init_addr_en === 1'b1) ia_a++;
      if (a.done === 1'b1) done_a++;
      if (b.data_load === 1'b1 && dl_prev_b !== 1'b1) rise_b++;
      if (b.done === 1'b1) done_b++;
    end
    dl_prev_a = a.data_load;
    dl_prev_b = b.data_load;
  end

  // Entered at the negedge where the block's data_load has just risen; leaves
  // at the negedge where the next block's data_load has risen (or after done).
  task automatic run_block(input int blk, input logic [31:0] base, input bit spur,
                           input bit restart, input bit new_img, input bit last);
    int ei, er, ec;
    ei = blk / 4; er = (blk / 2) % 2; ec = blk % 2;
    n_tests++;
    if ({a.img_idx, a.row_idx, a.col_idx} !== {2'(ei), 2'(er), 2'(ec)} || a.data_load !== 1'b1) begin
      n_fail++;
      $display("FAIL blk%0d_start: idx=%0d,%0d,%0d dl=%b expected %0d,%0d,%0d dl=1",
               blk, a.img_idx, a.row_idx, a.col_idx, a.data_load, ei, er, ec);
    end
    if (blk == 4) begin
      n_tests++;
      if (a.init_addr_en !== 1'b1 || a.init_addr !== base + 32'd896) begin
        n_fail++;
        $display("FAIL img1_init: en=%b addr=%0h expected en=1 addr=%0h", a.init_addr_en, a.init_addr, base + 32'd896);
      end
    end
    if (spur) begin
      @(negedge clk); a.result_valid = 1'b1;
      @(negedge clk); a.result_valid = 1'b0;
      n_tests++;
      if (a.data_load !== 1'b1 || a.col_idx !== 2'(ec)) begin
        n_fail++;
        $display("FAIL blk%0d_rv_in_load: dl=%b col=%0d expected dl=1 col=%0d", blk, a.data_load, a.col_idx, ec);
      end
      repeat (3) @(negedge clk);
      a.blkend = 1'b1; a.result_valid = 1'b1;
      @(negedge clk); a.result_valid = 1'b0;
    end else begin
      repeat (5) @(negedge clk);
      a.blkend = 1'b1;
      @(negedge clk); a.blkend = 1'b0;
    end
    n_tests++;
    if (a.data_load !== 1'b0 || a.col_idx !== 2'(ec)) begin
      n_fail++;
      $display("FAIL blk%0d_wait_res: dl=%b col=%0d expected dl=0 col=%0d", blk, a.data_load, a.col_idx, ec);
    end
    if (spur) begin
      repeat (10) @(negedge clk);
      n_tests++;
      if (a.data_load !== 1'b0 || a.col_idx !== 2'(ec)) begin
        n_fail++;
        $display("FAIL blk%0d_held_blkend: dl=%b col=%0d expected dl=0 col=%0d", blk, a.data_load, a.col_idx, ec);
      end
      a.blkend = 1'b0;
      @(negedge clk);
    end else if (restart) begin
      a.start = 1'b1; a.base_addr = 32'hDEAD_0000;
      @(negedge clk); a.start = 1'b0;
      repeat (10) @(negedge clk);
    end else begin
      repeat (11) @(negedge clk);
    end
    a.result_valid = 1'b1;
    @(negedge clk); a.result_valid = 1'b0;
    n_tests++;
    if (last) begin
      if (a.done !== 1'b1 || a.data_load !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse: done=%b dl=%b expected done=1 dl=0", a.done, a.data_load);
      end
      @(negedge clk);
      n_tests++;
      if (a.done !== 1'b0 || a.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_done: done=%b busy=%b expected 0 0", a.done, a.busy);
      end
    end else if (a.data_load !== 1'b1 || a.init_addr_en !== new_img || a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL blk%0d_next_rise: dl=%b init_en=%b done=%b expected dl=1 init_en=%b done=0",
               blk, a.data_load, a.init_addr_en, a.done, new_img);
    end
  endtask

  task automatic start_a(input logic [31:0] base);
    a.base_addr = base; a.start = 1'b1;
    @(negedge clk); a.start = 1'b0;
    n_tests++;
    if (a.init_addr_en !== 1'b1 || a.init_addr !== base || a.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: init_en=%b addr=%0h busy=%b expected 1 %0h 1", a.init_addr_en, a.init_addr, a.busy, base);
    end
  endtask

  task automatic run_batch(input logic [31:0] base, input bit spur, input bit restart);
    int r0, i0, d0;
    r0 = rise_a; i0 = ia_a; d0 = done_a;
    start_a(base);
    for (int i = 0; i < 8; i++)
      run_block(i, base, spur && (i % 2 == 1), restart && (i == 2), i == 3, i == 7);
    repeat (2) @(negedge clk);
    n_tests++;
    if (rise_a - r0 != 8 || ia_a - i0 != 2 || done_a - d0 != 1) begin
      n_fail++;
      $display("FAIL batch_counts: loads=%0d inits=%0d dones=%0d expected 8 2 1", rise_a - r0, ia_a - i0, done_a - d0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({a.data_load, a.init_addr_en, a.init_addr, a.busy, a.done, a.img_idx, a.row_idx, a.col_idx} !== '0 ||
        {b.data_load, b.init_addr_en, b.init_addr, b.busy, b.done, b.img_idx, b.row_idx, b.col_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: a.busy=%b a.dl=%b a.addr=%0h b.busy=%b expected all zero", a.busy, a.data_load, a.init_addr, b.busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_batch();       run_batch(32'h10, 1'b0, 1'b0); endtask
  task automatic test_spurious();         run_batch(32'h10, 1'b1, 1'b0); endtask
  task automatic test_start_while_busy(); run_batch(32'h10, 1'b0, 1'b1); endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_a;
    start_a(32'h10);
    run_block(0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_block(1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    a.blkend = 1'b1;
    @(negedge clk); a.blkend = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_tests++;
    if ({a.data_load, a.init_addr_en, a.init_addr, a.busy, a.done, a.img_idx, a.row_idx, a.col_idx} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: dl=%b busy=%b addr=%0h idx=%0d,%0d,%0d expected all zero",
               a.data_load, a.busy, a.init_addr, a.img_idx, a.row_idx, a.col_idx);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_a != d0 || a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: dones=%0d busy=%b expected 0 0", done_a - d0, a.busy);
    end
    run_batch(32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_degenerate();
    int r0, d0;
    r0 = rise_b; d0 = done_b;
    b.base_addr = 32'h40; b.start = 1'b1;
    @(negedge clk); b.start = 1'b0;
    n_tests++;
    if (b.init_addr_en !== 1'b1 || b.data_load !== 1'b1 || b.init_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL degen_init: en=%b dl=%b addr=%0h expected 1 1 40", b.init_addr_en, b.data_load, b.init_addr);
    end
    @(negedge clk);
    n_tests++;
    if (b.init_addr_en !== 1'b0 || b.data_load !== 1'b1) begin
      n_fail++;
      $display("FAIL degen_load: en=%b dl=%b expected 0 1", b.init_addr_en, b.data_load);
    end
    repeat (4) @(negedge clk);
    b.blkend = 1'b1;
    @(negedge clk); b.blkend = 1'b0;
    repeat (11) @(negedge clk);
    b.result_valid = 1'b1;
    @(negedge clk); b.result_valid = 1'b0;
    n_tests++;
    if (b.done !== 1'b1 || b.data_load !== 1'b0) begin
      n_fail++;
      $display("FAIL degen_done: done=%b dl=%b expected 1 0", b.done, b.data_load);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (rise_b - r0 != 1 || done_b - d0 != 1 || b.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL degen_counts: loads=%0d dones=%0d busy=%b expected 1 1 0", rise_b - r0, done_b - d0, b.busy);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    a.start = 1'b0; a.base_addr = '0; a.blkend = 1'b0; a.result_valid = 1'b0;
    b.start = 1'b0; b.base_addr = '0; b.blkend = 1'b0; b.result_valid = 1'b0;
    test_reset();
    test_full_batch();
    test_spurious();
    test_start_while_busy();
    test_reset_mid();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_buffer_scheduler.md
Name: input_buffer_scheduler

Overview:
Sequences input_buffer block loads across a whole input batch. It walks images, row-blocks and column-blocks in order. For each block it:
- raises data_load, plus init_addr_en/init_addr on the first block of each image;
- waits for the buffer's blkend;
- then waits for the compute array's result_valid before starting the next block.
It sits between the top-level layer controller (start/done) and input_buffer.

Parameters:
AW, 32, address width
IW, 224, input map width (pixels)
IH, 224, input map height (pixels)
IN, 10, images per batch
POY, 3, PE rows
STRIDE, 2, convolution stride
BURST, 32, buffer width per block (= BUFW)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin batch (sampled only in IDLE)
base_addr  in  AW  address of image 0; captured on accepted start
blkend  in  1  input_buffer: current block fully loaded
result_valid  in  1  compute array: current block results written
data_load  out  1  input_buffer load enable
init_addr_en  out  1  one-cycle strobe to load init_addr into input_buffer
init_addr  out  AW  image start address
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last block's result_valid
img_idx  out  $clog2(IN+1)  current image
row_idx  out  $clog2(NROW+1)  current row-block
col_idx  out  $clog2(NCOL+1)  current column-block

Behaviour:
- Derived constants:
  - LM = (STRIDE+1)*POY-STRIDE (7 by default).
  - NROW = IH/LM, integer floor (32 by default).
  - NCOL = IW/BURST (7 by default).
  - IMG_SZ = IH*IW (50176 by default).
- Elaboration check: $error if (POX-free) LM<1, NCOL<1 or NROW<1.
- All outputs registered. Reset value of every output and every index is 0; state is IDLE.
- FSM states: IDLE, INIT, LOAD, WAIT_RES, DONE.
- IDLE:
  - start=1 → INIT next cycle.
  - Captures base_addr into img_addr; clears the indices; busy<=1.
- INIT (exactly 1 cycle):
  - data_load=1, init_addr_en=1, init_addr=img_addr.
  - blkend is ignored in this state.
  - → LOAD.
- LOAD:
  - data_load=1, init_addr_en=0.
  - blkend=1 sampled → WAIT_RES; data_load falls the next cycle.
- WAIT_RES:
  - data_load=0.
  - result_valid=1 sampled → advance indices and choose the next state:
    - col_idx<NCOL-1: col_idx++ → LOAD.
    - else col_idx<=0; if row_idx<NROW-1: row_idx++ → LOAD.
    - else row_idx<=0; if img_idx<IN-1: img_idx++, img_addr+=IMG_SZ (AW-bit wrap allowed) → INIT.
    - else → DONE.
- DONE (1 cycle): done=1, busy<=0 → IDLE.
- Latencies:
  - Accepted start to init_addr_en = 1 cycle.
  - result_valid to next data_load rise = 1 cycle.
- Boundary and simultaneous events:
  - start while busy: ignored.
  - result_valid in LOAD/INIT/IDLE: ignored, no counter change.
  - blkend in WAIT_RES/IDLE: ignored.
  - blkend and result_valid high together in LOAD: only blkend acts.
  - Level-held blkend must not double-advance. Each block needs a fresh LOAD→WAIT_RES pass, and WAIT_RES reacts only to result_valid.
  - rst asserted mid-operation: next edge returns to IDLE with all outputs 0. No done is produced and no partial state is retained.
  - IN=1, NROW=1, NCOL=1: INIT→LOAD→WAIT_RES→DONE.

Decomposition:
- Package input_buffer_pkg holds:
  - sched_state_e enum (IDLE, INIT, LOAD, WAIT_RES, DONE);
  - function lm(poy, stride);
  - localparam helpers for NROW/NCOL/IMG_SZ, shared with input_buffer and buffer_if.
- One natural sub-module, blk_index_counter: a cascaded col/row/img counter with advance input, wrap flags and last_blk output. The FSM instantiates it.

Test Plan:
Bench parameters: IW=64, BURST=32, IH=14, POY=3, STRIDE=2 (LM=7, NCOL=2, NROW=2), IN=2, base_addr=32'h10. A behavioural buffer model returns blkend 5 cycles after data_load rises, and result_valid 12 cycles after blkend.
1. Single start → exactly 8 data_load high periods; init_addr_en pulses twice with init_addr=0x10 then 0x10+896=0x390; done pulses once after the 8th result_valid; busy low afterwards.
2. Index sequence → (img,row,col) visits (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…(1,1,1) in order; data_load rises exactly 1 cycle after each result_valid except the image change, which goes through INIT.
3. Spurious inputs: result_valid pulsed during LOAD, blkend held high through WAIT_RES → col_idx unchanged until the genuine result_valid; still 8 blocks total.
4. start pulsed again while busy → ignored; no extra init_addr_en; done count = 1.
5. rst asserted during block 3's WAIT_RES → next cycle all outputs 0, state IDLE; a new start with base_addr=0 replays from (0,0,0) with init_addr=0.
6. Degenerate IN=1, IH=7, IW=32 → INIT, LOAD, one blkend, one result_valid, done 1 cycle later; total 1 data_load period.
